stack_frame_sequencer: RTL and testbench

CPU-side sequencer that drives the hardware stack's push/pop interface to save or restore a contiguous register range in bulk, e.g. on interrupt entry and exit.
- Save: reads registers from the register file and pushes them onto the stack.
- Restore: pops values and writes them back in reverse order.
- Tracks stack occupancy, including single pushes/pops issued by other CPU logic, and flags overflow or underflow before any stack access is made.

---
 rtl/stack_frame_sequencer_if.sv | 37 +++
 rtl/stack_frame_sequencer.sv | 166 ++++++++++++++++
 tb/tb_stack_frame_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_frame_sequencer_if.sv
// Bus bundle for the stack frame sequencer: control handshake, register-file port and stack port.
// The master modport is the sequencer side; the slave modport is the CPU/register-file/stack side.
interface stack_frame_sequencer_if #(
  parameter int unsigned DEPTH_W = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 32
);
  logic              start_save;
  logic              start_restore;
  logic              busy;
  logic              done;
  logic              error;
  logic [DEPTH_W-1:0] depth;
  logic              ext_push;
  logic              ext_pop;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] stk_d;
  logic              stk_push;
  logic              stk_pop;
  logic [DATA_W-1:0] stk_q;

  modport master (
    input  start_save, start_restore, ext_push, ext_pop, rf_rdata, stk_q,
    output busy, done, error, depth, rf_raddr, rf_we, rf_waddr, rf_wdata,
           stk_d, stk_push, stk_pop
  );

  modport slave (
    output start_save, start_restore, ext_push, ext_pop, rf_rdata, stk_q,
    input  busy, done, error, depth, rf_raddr, rf_we, rf_waddr, rf_wdata,
           stk_d, stk_push, stk_pop
  );
endinterface

// File: rtl/stack_frame_sequencer.sv
// Bulk save/restore of a contiguous register range onto a hardware stack, with occupancy
// tracking that also observes single pushes/pops made by other CPU logic.
module stack_frame_sequencer #(
  parameter int unsigned FIRST_REG   = 1,
  parameter int unsigned LAST_REG    = 15,
  parameter int unsigned STACK_DEPTH = 128
) (
  input logic                    clk,
  input logic                    reset,
  stack_frame_sequencer_if.master bus
);
  localparam int unsigned N       = LAST_REG - FIRST_REG + 1;
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned CMP_W   = DEPTH_W + 1;
  localparam int unsigned CNT_W   = $clog2(N + 1);
  localparam int unsigned ADDR_W  = 4;

  typedef enum logic [2:0] {IDLE, CHECK, SAVE, RESTORE, FINISH} state_e;

  state_e             state_q, state_d;
  logic               save_op_q, save_op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [ADDR_W-1:0]  rf_raddr_q, rf_raddr_d;
  logic               rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic               stk_push_q, stk_push_d;
  logic               stk_pop_q, stk_pop_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      save_op_q  <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      depth_q    <= '0;
      rf_raddr_q <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      stk_push_q <= 1'b0;
      stk_pop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      save_op_q  <= save_op_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      depth_q    <= depth_d;
      rf_raddr_q <= rf_raddr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      stk_push_q <= stk_push_d;
      stk_pop_q  <= stk_pop_d;
    end
  end

  // Next state plus the registered outputs for the following cycle.
  always_comb begin
    state_d    = state_q;
    save_op_d  = save_op_q;
    cnt_d      = cnt_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    error_d    = error_q;
    depth_d    = depth_q;
    rf_raddr_d = '0;
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    stk_push_d = 1'b0;
    stk_pop_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_save && bus.start_restore) begin
          state_d = FINISH;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (bus.start_save || bus.start_restore) begin
          state_d   = CHECK;
          busy_d    = 1'b1;
          save_op_d = bus.start_save;
          if (bus.start_save) rf_raddr_d = ADDR_W'(FIRST_REG);
        end
      end
      CHECK: begin
        cnt_d = '0;
        if (save_op_q ? (CMP_W'(depth_q) + CMP_W'(N) > CMP_W'(STACK_DEPTH))
                      : (depth_q < DEPTH_W'(N))) begin
          state_d = FINISH;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (save_op_q) begin
          state_d    = SAVE;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          stk_push_d = 1'b1;
          rf_raddr_d = rf_raddr_q + ADDR_W'(1);
        end else begin
          state_d   = RESTORE;
          busy_d    = 1'b1;
          error_d   = 1'b0;
          stk_pop_d = 1'b1;
        end
      end
      SAVE: begin
        // Read data trails the address by one cycle, so the push stream lags rf_raddr.
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          busy_d     = 1'b1;
          stk_push_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          rf_raddr_d = rf_raddr_q + ADDR_W'(1);
        end
      end
      RESTORE: begin
        // One extra cycle after the last pop to write back the final stk_q.
        if (cnt_q == CNT_W'(N)) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          busy_d     = 1'b1;
          rf_we_d    = 1'b1;
          rf_waddr_d = ADDR_W'(LAST_REG - 32'(cnt_q));
          stk_pop_d  = (cnt_q < CNT_W'(N - 1));
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (stk_push_q)     depth_d = depth_q + DEPTH_W'(1);
    else if (stk_pop_q) depth_d = depth_q - DEPTH_W'(1);

    // External single accesses: counted when not busy, flagged and dropped while busy.
    if (busy_q) begin
      if (bus.ext_push || bus.ext_pop) error_d = 1'b1;
    end else if (bus.ext_push && !bus.ext_pop) begin
      if (depth_q == DEPTH_W'(STACK_DEPTH)) error_d = 1'b1;
      else                                  depth_d = depth_q + DEPTH_W'(1);
    end else if (bus.ext_pop && !bus.ext_push) begin
      if (depth_q == '0) error_d = 1'b1;
      else               depth_d = depth_q - DEPTH_W'(1);
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.depth    = depth_q;
  assign bus.rf_raddr = rf_raddr_q;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.stk_push = stk_push_q;
  assign bus.stk_pop  = stk_pop_q;
  assign bus.stk_d    = stk_push_q ? bus.rf_rdata : '0;
  assign bus.rf_wdata = rf_we_q ? bus.stk_q : '0;
endmodule

// File: tb/tb_stack_frame_sequencer.sv
// Scoreboard bench for stack_frame_sequencer with a register-file model and a stack model.
module tb_stack_frame_sequencer;
  localparam int unsigned FIRST  = 1;
  localparam int unsigned LAST   = 15;
  localparam int unsigned N      = LAST - FIRST + 1;
  localparam int unsigned SDEPTH = 128;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [3:0]  addr;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_frame_sequencer_if bus();

  stack_frame_sequencer #(.FIRST_REG(FIRST), .LAST_REG(LAST), .STACK_DEPTH(SDEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ev_t         push_q[$];
  ev_t         pop_q[$];
  ev_t         wr_q[$];
  logic [31:0] sh[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_depth;
  bit          exp_err;
  logic        rf_load = 1'b0;
  logic        rf_clr = 1'b0;
  logic [31:0] rf [16];
  logic [31:0] mem [128];
  int          sp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: one-cycle read latency.
  always @(posedge clk) begin
    bus.rf_rdata <= rf[bus.rf_raddr];
    if (rf_load)         for (int i = 0; i < 16; i++) rf[i] <= 32'h100 + 32'(i);
    else if (rf_clr)     for (int i = 0; i < 16; i++) rf[i] <= '0;
    else if (bus.rf_we)  rf[bus.rf_waddr] <= bus.rf_wdata;
  end

  // Stack: shares the sequencer reset; external accesses land only when the sequencer is not strobing.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp        <= 0;
      bus.stk_q <= '0;
    end else if (bus.stk_push) begin
      mem[7'(sp)] <= bus.stk_d;
      sp          <= sp + 1;
    end else if (bus.stk_pop) begin
      bus.stk_q <= mem[7'(sp - 1)];
      sp        <= sp - 1;
    end else if (bus.ext_push && !bus.ext_pop && sp < 128) begin
      mem[7'(sp)] <= 32'hE000_0000 + 32'(sp);
      sp          <= sp + 1;
    end else if (bus.ext_pop && !bus.ext_push && sp > 0) begin
      sp <= sp - 1;
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (reset === 1'b1) begin
      if (bus.stk_push || bus.stk_pop)
        check_eq("strobe_exclusive", 32'(bus.stk_push & bus.stk_pop), 32'(0));
      if (bus.stk_push) begin
        if (push_q.size() == 0) check_eq("push_unexpected", 32'(1), 32'(0));
        else begin
          e = push_q.pop_front();
          check_eq("push_cycle", 32'(cyc), 32'(e.cyc));
          check_eq("push_data", bus.stk_d, e.data);
        end
      end
      if (bus.stk_pop) begin
        if (pop_q.size() == 0) check_eq("pop_unexpected", 32'(1), 32'(0));
        else begin
          e = pop_q.pop_front();
          check_eq("pop_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.rf_we) begin
        if (wr_q.size() == 0) check_eq("write_unexpected", 32'(1), 32'(0));
        else begin
          e = wr_q.pop_front();
          check_eq("write_cycle", 32'(cyc), 32'(e.cyc));
          check_eq("write_addr", 32'(bus.rf_waddr), 32'(e.addr));
          check_eq("write_data", bus.rf_wdata, e.data);
        end
      end
    end
  end

  task automatic do_start(input bit s, input bit r, output int t);
    @(posedge clk); #1;
    bus.start_save    = s;
    bus.start_restore = r;
    t = cyc;
    @(posedge clk); #1;
    bus.start_save    = 1'b0;
    bus.start_restore = 1'b0;
  endtask

  task automatic check_busy(input string tag);
    @(negedge clk);
    check_eq(tag, 32'(bus.busy), 32'(1));
  endtask

  task automatic enqueue_save(input int t);
    logic [31:0] v;
    for (int k = 0; k < int'(N); k++) begin
      v = 32'h100 + 32'(FIRST) + 32'(k);
      push_q.push_back('{t + 2 + k, v, 4'(0)});
      sh.push_back(v);
    end
    exp_depth += N;
  endtask

  task automatic enqueue_restore(input int t);
    logic [31:0] v;
    for (int k = 0; k < int'(N); k++) begin
      pop_q.push_back('{t + 2 + k, 32'(0), 4'(0)});
      v = sh.pop_back();
      wr_q.push_back('{t + 3 + k, v, 4'(int'(LAST) - k)});
    end
    exp_depth -= N;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'(1));
    if (seen) begin
      check_eq({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
      check_eq({tag, "_busy_at_done"}, 32'(bus.busy), 32'(0));
      check_eq({tag, "_error"}, 32'(bus.error), 32'(exp_err));
      check_eq({tag, "_depth"}, 32'(bus.depth), 32'(exp_depth));
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'(0));
    end
    check_eq({tag, "_sb_empty"}, 32'(push_q.size() + pop_q.size() + wr_q.size()), 32'(0));
  endtask

  task automatic ext_ops(input bit p, input bit q, input int n);
    @(posedge clk); #1;
    bus.ext_push = p;
    bus.ext_pop  = q;
    repeat (n) @(posedge clk);
    #1;
    bus.ext_push = 1'b0;
    bus.ext_pop  = 1'b0;
  endtask

  task automatic ext_push_n(input int n);
    for (int j = 0; j < n; j++) begin
      sh.push_back(32'hE000_0000 + 32'(exp_depth));
      exp_depth++;
    end
    ext_ops(1'b1, 1'b0, n);
  endtask

  task automatic ext_pop_n(input int n);
    for (int j = 0; j < n; j++) begin
      void'(sh.pop_back());
      exp_depth--;
    end
    ext_ops(1'b0, 1'b1, n);
  endtask

  task automatic rf_pulse(input bit load);
    @(posedge clk); #1;
    if (load) rf_load = 1'b1;
    else      rf_clr  = 1'b1;
    @(posedge clk); #1;
    rf_load = 1'b0;
    rf_clr  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    reset             = 1'b0;
    bus.start_save    = 1'b0;
    bus.start_restore = 1'b0;
    bus.ext_push      = 1'b0;
    bus.ext_pop       = 1'b0;
    rf_load           = 1'b1;
    repeat (3) @(posedge clk);
    #1 rf_load = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy), 32'(0));
    check_eq("rst_done", 32'(bus.done), 32'(0));
    check_eq("rst_error", 32'(bus.error), 32'(0));
    check_eq("rst_depth", 32'(bus.depth), 32'(0));
    check_eq("rst_push", 32'(bus.stk_push), 32'(0));
    check_eq("rst_pop", 32'(bus.stk_pop), 32'(0));
    check_eq("rst_rf_we", 32'(bus.rf_we), 32'(0));
    check_eq("rst_raddr", 32'(bus.rf_raddr), 32'(0));
    check_eq("rst_stk_d", bus.stk_d, 32'(0));
    @(posedge clk); #1 reset = 1'b1;
    exp_depth = 0;
    exp_err   = 1'b0;

    // Frame save then restore of R1..R15.
    do_start(1'b1, 1'b0, t);
    enqueue_save(t);
    check_busy("save_busy");
    wait_done("save", t + int'(N) + 2);
    ext_ops(1'b1, 1'b1, 1);
    @(negedge clk);
    check_eq("ext_both_depth", 32'(bus.depth), 32'(15));
    check_eq("ext_both_error", 32'(bus.error), 32'(0));

    rf_pulse(1'b0);
    do_start(1'b0, 1'b1, t);
    enqueue_restore(t);
    check_busy("restore_busy");
    wait_done("restore", t + int'(N) + 3);
    for (int i = int'(FIRST); i <= int'(LAST); i++)
      check_eq("restored_reg", rf[i], 32'h100 + 32'(i));

    // ext_pop on an empty stack.
    exp_err = 1'b1;
    ext_ops(1'b0, 1'b1, 1);
    @(negedge clk);
    check_eq("ext_pop_empty_depth", 32'(bus.depth), 32'(0));
    check_eq("ext_pop_empty_error", 32'(bus.error), 32'(1));

    // Save that would overflow at depth 120.
    ext_push_n(120);
    @(negedge clk);
    check_eq("depth_120", 32'(bus.depth), 32'(120));
    rf_pulse(1'b1);
    do_start(1'b1, 1'b0, t);
    check_busy("save_ovf_busy");
    wait_done("save_ovf", t + 2);

    // ext_push at full.
    ext_push_n(8);
    ext_ops(1'b1, 1'b0, 1);
    @(negedge clk);
    check_eq("ext_push_full_depth", 32'(bus.depth), 32'(128));
    check_eq("ext_push_full_error", 32'(bus.error), 32'(1));

    // Restore that would underflow at depth 14, then a legal one at 15.
    ext_pop_n(114);
    @(negedge clk);
    check_eq("depth_14", 32'(bus.depth), 32'(14));
    do_start(1'b0, 1'b1, t);
    check_busy("restore_udf_busy");
    wait_done("restore_udf", t + 2);
    ext_push_n(1);
    do_start(1'b0, 1'b1, t);
    enqueue_restore(t);
    exp_err = 1'b0;
    check_busy("restore_ok_busy");
    wait_done("restore_ok", t + int'(N) + 3);

    // Conflicting starts.
    exp_err = 1'b1;
    do_start(1'b1, 1'b1, t);
    wait_done("both_starts", t + 1);

    // ext_push while a save is running.
    rf_pulse(1'b1);
    do_start(1'b1, 1'b0, t);
    enqueue_save(t);
    check_busy("save_ext_busy");
    while (cyc < t + 5) begin
      @(posedge clk); #1;
    end
    check_eq("save_ext_err_cleared", 32'(bus.error), 32'(0));
    bus.ext_push = 1'b1;
    @(posedge clk); #1;
    bus.ext_push = 1'b0;
    wait_done("save_ext", t + int'(N) + 2);

    // Reset in the middle of a save.
    do_start(1'b1, 1'b0, t);
    enqueue_save(t);
    check_busy("save_rst_busy");
    while (cyc < t + 8) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check_eq("midrst_push", 32'(bus.stk_push), 32'(0));
    check_eq("midrst_busy", 32'(bus.busy), 32'(0));
    check_eq("midrst_depth", 32'(bus.depth), 32'(0));
    check_eq("midrst_done", 32'(bus.done), 32'(0));
    push_q.delete();
    sh.delete();
    exp_depth = 0;
    exp_err   = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_eq("postrst_error", 32'(bus.error), 32'(0));
    check_eq("postrst_depth", 32'(bus.depth), 32'(0));
    do_start(1'b1, 1'b0, t);
    enqueue_save(t);
    check_busy("save_after_rst_busy");
    wait_done("save_after_rst", t + int'(N) + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
